// File: rtl/ltssm_pkg.sv
// Shared LTSSM definitions: sub-state codes, ordered-set types and the
// per-sub-state transmit plan. The RX checker uses the same sub-state codes.
package ltssm_pkg;

  localparam int unsigned        CNT_W           = 11;
  localparam logic [CNT_W-1:0]   MIN_POLL_ACTIVE = 11'd1024;
  localparam logic [CNT_W-1:0]   POST_TS_IDL     = 11'd16;

  typedef enum logic [3:0] {
    SS_DETECT_QUIET     = 4'd0,
    SS_DETECT_ACTIVE    = 4'd1,
    SS_POLLING_ACTIVE   = 4'd2,
    SS_POLLING_CONFIG   = 4'd3,
    SS_CFG_LW_START     = 4'd4,
    SS_CFG_LW_ACCEPT    = 4'd5,
    SS_CFG_LN_WAIT      = 4'd6,
    SS_CFG_LN_ACCEPT    = 4'd7,
    SS_CFG_COMPLETE     = 4'd8,
    SS_CFG_IDLE         = 4'd9
  } substate_e;

  typedef enum logic [2:0] {
    OS_NONE = 3'd0,
    OS_TS1  = 3'd1,
    OS_TS2  = 3'd2,
    OS_IDL  = 3'd3,
    OS_EIOS = 3'd4
  } os_type_e;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_SEND  = 2'd1,
    TX_DRAIN = 2'd2,
    TX_DONE  = 2'd3
  } tx_state_e;

  typedef struct packed {
    os_type_e         typ;
    logic [CNT_W-1:0] min_cnt;
    logic [CNT_W-1:0] post_cnt;
    logic             bad;      // unknown sub-state code, finish as failure
  } os_plan_t;

  // Ordered-set type, minimum TX count and post-exit count for a sub-state.
  function automatic os_plan_t os_plan(input logic [3:0] s);
    os_plan_t p;
    p.typ      = OS_NONE;
    p.min_cnt  = '0;
    p.post_cnt = '0;
    p.bad      = 1'b0;
    case (s)
      SS_DETECT_QUIET, SS_DETECT_ACTIVE: p.typ = OS_NONE;
      SS_POLLING_ACTIVE: begin
        p.typ     = OS_TS1;
        p.min_cnt = MIN_POLL_ACTIVE;
      end
      SS_POLLING_CONFIG: begin
        p.typ      = OS_TS2;
        p.post_cnt = POST_TS_IDL;
      end
      SS_CFG_LW_START, SS_CFG_LW_ACCEPT,
      SS_CFG_LN_WAIT, SS_CFG_LN_ACCEPT: p.typ = OS_TS1;
      SS_CFG_COMPLETE: begin
        p.typ      = OS_TS2;
        p.post_cnt = POST_TS_IDL;
      end
      SS_CFG_IDLE: begin
        p.typ      = OS_IDL;
        p.post_cnt = POST_TS_IDL;
      end
      default: p.bad = 1'b1;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/tx_os_counter.sv
// Saturating handshake counter with synchronous clear. ge_o compares the
// count including the increment of this cycle, so a decision can be taken in
// the same cycle as the handshake that reaches the threshold.
module tx_os_counter
  import ltssm_pkg::*;
#(
  parameter int unsigned W = CNT_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr_i,
  input  logic         inc_i,
  input  logic [W-1:0] thr_i,
  output logic         ge_o
);

  localparam logic [W-1:0] CNT_MAX = '1;
  localparam logic [W-1:0] ONE     = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: clear wins, otherwise increment until saturated.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                          cnt_d = '0;
    else if (inc_i && cnt_q != CNT_MAX) cnt_d = cnt_q + ONE;
  end

  // Count register, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign ge_o = ({1'b0, cnt_q} + {{W{1'b0}}, inc_i}) >= {1'b0, thr_i};

endmodule

// File: rtl/master_tx_ltssm.sv
// TX side of the LTSSM sub-state sequencer: offers the ordered set each
// sub-state needs, counts accepted sets, merges the RX checker verdict and
// reports finish/exitTo to the main LTSSM.
module master_tx_ltssm
  import ltssm_pkg::*;
#(
  parameter int MAXLANES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] substate,
  input  logic       rxFinish,
  input  logic [3:0] rxExitTo,
  input  logic       osReady,
  output logic       osValid,
  output logic [2:0] osType,
  output logic       txElectricalIdle,
  output logic       finish,
  output logic [3:0] exitTo
);

  if (MAXLANES < 1) begin : g_lanes_chk
    $error("MAXLANES must be at least 1");
  end

  tx_state_e  state_q, state_d;
  logic [3:0] cur_q, cur_d, last_q, last_d, rxexit_q, rxexit_d;
  logic       rxseen_q, rxseen_d, rxok_q, rxok_d;
  logic       osvalid_q, osvalid_d, txei_q, txei_d, finish_q, finish_d;
  os_type_e   ostype_q, ostype_d;
  logic [3:0] exitto_q, exitto_d;

  os_plan_t   req_plan, cur_plan;
  logic       hs, pending, new_req;
  logic       seen_e, ok_e;
  logic [3:0] exit_e;
  logic       tx_clr, tx_ge, post_ge;
  logic       go_done;
  logic [3:0] done_exit;

  assign req_plan = os_plan(substate);
  assign cur_plan = os_plan(cur_q);
  assign hs       = osvalid_q & osReady;
  assign pending  = osvalid_q & ~osReady;
  assign new_req  = (substate != last_q);

  // An rxFinish in this cycle counts as already seen.
  assign seen_e = rxseen_q | rxFinish;
  assign ok_e   = rxseen_q ? rxok_q   : (rxExitTo != 4'd0);
  assign exit_e = rxseen_q ? rxexit_q : rxExitTo;
  assign tx_clr = (state_q == TX_IDLE) & new_req;

  tx_os_counter u_tx_cnt (
    .clk   (clk),
    .reset (reset),
    .clr_i (tx_clr),
    .inc_i (hs & (state_q == TX_SEND)),
    .thr_i (cur_plan.min_cnt),
    .ge_o  (tx_ge)
  );

  tx_os_counter u_post_cnt (
    .clk   (clk),
    .reset (reset),
    .clr_i (tx_clr),
    .inc_i (hs & (state_q == TX_DRAIN)),
    .thr_i (cur_plan.post_cnt),
    .ge_o  (post_ge)
  );

  // Next-state and registered-output logic. Leaving SEND/DRAIN waits for a
  // pending ordered set so osValid never drops without a handshake.
  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    last_d    = last_q;
    rxseen_d  = rxseen_q;
    rxok_d    = rxok_q;
    rxexit_d  = rxexit_q;
    osvalid_d = osvalid_q;
    ostype_d  = ostype_q;
    txei_d    = txei_q;
    finish_d  = 1'b0;
    exitto_d  = exitto_q;
    go_done   = 1'b0;
    done_exit = 4'd0;
    case (state_q)
      TX_IDLE: begin
        if (new_req) begin
          cur_d    = substate;
          rxseen_d = 1'b0;
          rxok_d   = 1'b0;
          rxexit_d = 4'd0;
          if (req_plan.bad) begin
            go_done = 1'b1;
          end else begin
            state_d   = TX_SEND;
            osvalid_d = (req_plan.typ != OS_NONE);
            ostype_d  = req_plan.typ;
            txei_d    = (req_plan.typ == OS_NONE);
          end
        end
      end
      TX_SEND: begin
        if (rxFinish && !rxseen_q) begin
          rxseen_d = 1'b1;
          rxok_d   = (rxExitTo != 4'd0);
          rxexit_d = rxExitTo;
        end
        if (seen_e && !pending) begin
          if (!ok_e) begin
            go_done = 1'b1;
          end else if (tx_ge) begin
            if (cur_plan.post_cnt == '0) begin
              go_done   = 1'b1;
              done_exit = exit_e;
            end else begin
              state_d = TX_DRAIN;
            end
          end
        end
      end
      TX_DRAIN: begin
        if (post_ge && !pending) begin
          go_done   = 1'b1;
          done_exit = rxexit_q;
        end
      end
      TX_DONE: begin
        state_d = TX_IDLE;
        last_d  = cur_q;
      end
      default: state_d = TX_IDLE;
    endcase
    if (go_done) begin
      state_d   = TX_DONE;
      finish_d  = 1'b1;
      exitto_d  = done_exit;
      osvalid_d = 1'b0;
      ostype_d  = OS_NONE;
    end
  end

  // State and output registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= TX_IDLE;
      cur_q     <= 4'd0;
      last_q    <= 4'hF;
      rxseen_q  <= 1'b0;
      rxok_q    <= 1'b0;
      rxexit_q  <= 4'd0;
      osvalid_q <= 1'b0;
      ostype_q  <= OS_NONE;
      txei_q    <= 1'b1;
      finish_q  <= 1'b0;
      exitto_q  <= 4'd0;
    end else begin
      state_q   <= state_d;
      cur_q     <= cur_d;
      last_q    <= last_d;
      rxseen_q  <= rxseen_d;
      rxok_q    <= rxok_d;
      rxexit_q  <= rxexit_d;
      osvalid_q <= osvalid_d;
      ostype_q  <= ostype_d;
      txei_q    <= txei_d;
      finish_q  <= finish_d;
      exitto_q  <= exitto_d;
    end
  end

  assign osValid          = osvalid_q;
  assign osType           = ostype_q;
  assign txElectricalIdle = txei_q;
  assign finish           = finish_q;
  assign exitTo           = exitto_q;

endmodule

// File: tb/tb_master_tx_ltssm.sv
// Bench for master_tx_ltssm: a request-level reference model checked every
// cycle, plus directed scenarios with hand-computed totals and exit codes.
module tb_master_tx_ltssm;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] substate = 4'hF;
  logic       rxFinish = 1'b0;
  logic [3:0] rxExitTo = 4'd0;
  logic       osReady = 1'b0;
  logic       osValid;
  logic [2:0] osType;
  logic       txElectricalIdle;
  logic       finish;
  logic [3:0] exitTo;

  master_tx_ltssm #(.MAXLANES(16)) dut (
    .clk              (clk),
    .reset            (reset),
    .substate         (substate),
    .rxFinish         (rxFinish),
    .rxExitTo         (rxExitTo),
    .osReady          (osReady),
    .osValid          (osValid),
    .osType           (osType),
    .txElectricalIdle (txElectricalIdle),
    .finish           (finish),
    .exitTo           (exitTo)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Sub-state table: ordered-set type, minimum count, post count.
  int tbl_type[16], tbl_min[16], tbl_post[16];
  initial begin
    for (int i = 0; i < 16; i++) begin
      tbl_type[i] = 0; tbl_min[i] = 0; tbl_post[i] = 0;
    end
    tbl_type[2] = 1; tbl_min[2] = 1024;
    tbl_type[3] = 2; tbl_post[3] = 16;
    for (int i = 4; i < 8; i++) tbl_type[i] = 1;
    tbl_type[8] = 2; tbl_post[8] = 16;
    tbl_type[9] = 3; tbl_post[9] = 16;
  end

  // Reference model: one request at a time, counts accepted sets, remembers
  // the RX verdict and decides when the request completes.
  int m_last, m_cur, m_sent, m_post_left, m_rx_exit;
  bit m_busy, m_rx, m_rx_ok;
  bit e_valid, e_ei, e_fin;
  int e_type, e_exit;

  task automatic m_finish(input int x);
    e_fin = 1'b1; e_exit = x; e_valid = 1'b0; e_type = 0;
  endtask

  always @(posedge clk) begin
    bit mhs, stall;
    if (!reset) begin
      m_last = 15; m_busy = 0; m_post_left = -1; m_rx = 0; m_sent = 0;
      e_valid = 0; e_type = 0; e_ei = 1; e_fin = 0; e_exit = 0;
    end else begin
      mhs   = e_valid && osReady;
      stall = e_valid && !osReady;
      if (e_fin) begin
        e_fin = 0; m_last = m_cur; m_busy = 0;
      end else if (!m_busy) begin
        if (int'(substate) != m_last) begin
          m_cur = int'(substate); m_sent = 0; m_rx = 0; m_post_left = -1; m_busy = 1;
          if (m_cur > 9) m_finish(0);
          else begin
            e_type = tbl_type[m_cur]; e_valid = (e_type != 0); e_ei = (e_type == 0);
          end
        end
      end else if (m_post_left < 0) begin
        if (mhs) m_sent++;
        if (rxFinish && !m_rx) begin
          m_rx = 1; m_rx_ok = (rxExitTo != 0); m_rx_exit = int'(rxExitTo);
        end
        if (m_rx && !stall) begin
          if (!m_rx_ok) m_finish(0);
          else if (m_sent >= tbl_min[m_cur]) begin
            if (tbl_post[m_cur] == 0) m_finish(m_rx_exit);
            else m_post_left = tbl_post[m_cur];
          end
        end
      end else begin
        if (mhs) m_post_left--;
        if (m_post_left == 0) m_finish(m_rx_exit);
      end
    end
  end

  // Handshake monitor: total accepted sets and the cycle of the last one.
  int cyc = 0, hs_cnt = 0, last_hs = -1;
  always @(posedge clk) begin
    if (osValid && osReady) begin
      hs_cnt++; last_hs = cyc;
    end
    cyc++;
  end

  // Every-cycle compare against the model.
  always @(negedge clk) begin
    if (chk_en)
      chk("outputs", {20'd0, osValid, osType, txElectricalIdle, finish, exitTo},
          {20'd0, e_valid, e_type[2:0], e_ei, e_fin, e_exit[3:0]});
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Waits for finish, optionally toggling osReady each cycle.
  task automatic run_until_finish(input int budget, input bit toggle, output int fin_cyc);
    bit found = 0;
    fin_cyc = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (finish) begin found = 1; fin_cyc = cyc; break; end
      @(posedge clk); #1;
      if (toggle) osReady = ~osReady;
    end
    chk("finish_seen", 32'(found), 32'd1);
  endtask

  initial begin
    int base, fc;
    tick(1);
    chk_en = 1'b1;
    tick(1);
    chk("rst_valid", 32'(osValid), 32'd0);
    chk("rst_type", 32'(osType), 32'd0);
    chk("rst_ei", 32'(txElectricalIdle), 32'd1);
    chk("rst_finish", 32'(finish), 32'd0);
    chk("rst_exit", 32'(exitTo), 32'd0);
    reset = 1'b1;
    tick(2);

    // pollingActive: 1024 TS1 required, rxFinish early.
    substate = 4'd2; osReady = 1'b1; base = hs_cnt;
    tick(20);
    rxFinish = 1'b1; rxExitTo = 4'd3;
    tick(1);
    rxFinish = 1'b0;
    run_until_finish(1200, 0, fc);
    chk("pa_total", 32'(hs_cnt - base), 32'd1024);
    chk("pa_timing", 32'(fc), 32'(last_hs + 1));
    chk("pa_exit", 32'(exitTo), 32'd3);
    tick(5);
    chk("pa_no_rereq", 32'(osValid), 32'd0);

    // pollingConfiguration: rxFinish on the 5th TS2, then 16 more.
    substate = 4'd3; base = hs_cnt;
    for (int i = 0; i < 50 && (hs_cnt - base) < 4; i++) tick(1);
    rxFinish = 1'b1; rxExitTo = 4'd4;
    tick(1);
    rxFinish = 1'b0;
    run_until_finish(100, 0, fc);
    chk("pc_total", 32'(hs_cnt - base), 32'd21);
    chk("pc_exit", 32'(exitTo), 32'd4);
    tick(1);

    // RX failure while an ordered set is stalled.
    substate = 4'd5; osReady = 1'b0; base = hs_cnt;
    tick(2);
    rxFinish = 1'b1; rxExitTo = 4'd0;
    tick(1);
    rxFinish = 1'b0;
    tick(2);
    chk("rf_stall_valid", 32'(osValid), 32'd1);
    chk("rf_stall_type", 32'(osType), 32'd1);
    osReady = 1'b1;
    tick(1);
    osReady = 1'b0;
    run_until_finish(20, 0, fc);
    chk("rf_total", 32'(hs_cnt - base), 32'd1);
    chk("rf_timing", 32'(fc), 32'(last_hs + 1));
    chk("rf_exit", 32'(exitTo), 32'd0);
    tick(1);

    // Back-pressure on IDL: rxFinish on the 3rd accepted set, 16 more after.
    substate = 4'd9; osReady = 1'b0; base = hs_cnt;
    for (int i = 0; i < 50; i++) begin
      tick(1);
      osReady = ~osReady;
      if (osReady && (hs_cnt - base) == 2) break;
    end
    rxFinish = 1'b1; rxExitTo = 4'd7;
    tick(1);
    rxFinish = 1'b0; osReady = ~osReady;
    run_until_finish(200, 1, fc);
    chk("bp_total", 32'(hs_cnt - base), 32'd19);
    chk("bp_exit", 32'(exitTo), 32'd7);
    osReady = 1'b0;
    tick(5);
    chk("bp_no_rereq", 32'(osValid), 32'd0);

    // New request, then reset in DRAIN.
    substate = 4'd8; osReady = 1'b1;
    tick(2);
    rxFinish = 1'b1; rxExitTo = 4'd9;
    tick(1);
    rxFinish = 1'b0;
    tick(5);
    chk("dr_active", 32'(osValid), 32'd1);
    reset = 1'b0; substate = 4'd12;
    tick(1);
    chk("mid_rst_valid", 32'(osValid), 32'd0);
    chk("mid_rst_type", 32'(osType), 32'd0);
    chk("mid_rst_ei", 32'(txElectricalIdle), 32'd1);
    chk("mid_rst_finish", 32'(finish), 32'd0);
    chk("mid_rst_exit", 32'(exitTo), 32'd0);
    reset = 1'b1; base = hs_cnt;

    // Unknown code 12 fails straight away.
    run_until_finish(5, 0, fc);
    chk("bad_exit", 32'(exitTo), 32'd0);
    chk("bad_total", 32'(hs_cnt - base), 32'd0);
    tick(1);

    // configurationLinkWidthStart: TS1, no minimum, no post.
    substate = 4'd4;
    tick(3);
    rxFinish = 1'b1; rxExitTo = 4'd6;
    tick(1);
    rxFinish = 1'b0;
    run_until_finish(10, 0, fc);
    chk("lw_exit", 32'(exitTo), 32'd6);
    chk("lw_ei", 32'(txElectricalIdle), 32'd0);
    tick(1);

    // detectQuiet: electrical idle, nothing offered.
    substate = 4'd0;
    tick(3);
    chk("dq_valid", 32'(osValid), 32'd0);
    rxFinish = 1'b1; rxExitTo = 4'd1;
    tick(1);
    rxFinish = 1'b0;
    run_until_finish(10, 0, fc);
    chk("dq_exit", 32'(exitTo), 32'd1);
    chk("dq_ei", 32'(txElectricalIdle), 32'd1);
    tick(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
